// File: rtl/memory_access_if.sv
// Data-memory req/ack port between the memory-access stage (master) and the data memory (slave).
interface memory_access_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/memory_access.sv
// Memory-access pipeline stage: issues loads/stores over a req/ack port with lane steering,
// extension, alignment faults and ack timeout; registers results for writeback.
module memory_access #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   valid_i,
    input  logic [31:0]            alu_result_i,
    input  logic [31:0]            write_data_i,
    input  logic                   mem_read_i,
    input  logic                   mem_write_i,
    input  logic [2:0]             funct3_i,
    input  logic [4:0]             rd_i,
    input  logic                   reg_write_i,
    input  logic                   mem_to_reg_i,
    output logic                   stall_o,
    output logic                   valid_o,
    output logic [31:0]            read_data_o,
    output logic [31:0]            alu_result_o,
    output logic [4:0]             rd_o,
    output logic                   reg_write_o,
    output logic                   mem_to_reg_o,
    output logic                   misaligned_o,
    output logic                   bus_error_o,
    memory_access_if.master        dmem
);
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [0:0] {StIdle, StAccess} state_e;

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic [31:0]     addr_q;
    logic [2:0]      funct3_q;
    logic [4:0]      rd_q;
    logic            reg_write_q;
    logic            mem_to_reg_q;
    logic            req_q, we_q;
    logic [3:0]      be_q;
    logic [31:0]     wdata_q;
    logic            valid_q, misaligned_q, bus_error_q;
    logic [31:0]     read_data_q, alu_result_q;
    logic [4:0]      rd_out_q;
    logic            reg_write_out_q, mem_to_reg_out_q;

    logic        mem_op, aligned, timeout, done;
    logic [3:0]  be_d;
    logic [31:0] wdata_d, lane, load_d;

    always_comb begin
        mem_op = mem_read_i | mem_write_i;
        unique case (funct3_i[1:0])
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = ~alu_result_i[0];
            2'b10:   aligned = (alu_result_i[1:0] == 2'b00);
            default: aligned = 1'b0;
        endcase
        unique case (funct3_i[1:0])
            2'b00:   begin be_d = 4'b0001 << alu_result_i[1:0];
                           wdata_d = {4{write_data_i[7:0]}}; end
            2'b01:   begin be_d = 4'b0011 << {alu_result_i[1], 1'b0};
                           wdata_d = {2{write_data_i[15:0]}}; end
            default: begin be_d = 4'b1111; wdata_d = write_data_i; end
        endcase
        // Timeout fires on the ACCESS cycle whose increment would reach the limit; ack wins.
        timeout = (state_q == StAccess) && !dmem.dmem_ack &&
                  (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
        done    = (state_q == StAccess) && (dmem.dmem_ack || timeout);
        stall_o = ((state_q == StIdle) && valid_i && mem_op && aligned) ||
                  ((state_q == StAccess) && !dmem.dmem_ack && !timeout);
        lane    = dmem.dmem_rdata >> {addr_q[1:0], 3'b000};
        unique case (funct3_q)
            3'b000:  load_d = {{24{lane[7]}}, lane[7:0]};
            3'b001:  load_d = {{16{lane[15]}}, lane[15:0]};
            3'b100:  load_d = {24'h0, lane[7:0]};
            3'b101:  load_d = {16'h0, lane[15:0]};
            default: load_d = dmem.dmem_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= StIdle;
            cnt_q            <= '0;
            addr_q           <= '0;
            funct3_q         <= '0;
            rd_q             <= '0;
            reg_write_q      <= 1'b0;
            mem_to_reg_q     <= 1'b0;
            req_q            <= 1'b0;
            we_q             <= 1'b0;
            be_q             <= '0;
            wdata_q          <= '0;
            valid_q          <= 1'b0;
            misaligned_q     <= 1'b0;
            bus_error_q      <= 1'b0;
            read_data_q      <= '0;
            alu_result_q     <= '0;
            rd_out_q         <= '0;
            reg_write_out_q  <= 1'b0;
            mem_to_reg_out_q <= 1'b0;
        end else begin
            valid_q      <= 1'b0;
            misaligned_q <= 1'b0;
            bus_error_q  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (valid_i && mem_op && aligned) begin
                        state_q      <= StAccess;
                        cnt_q        <= '0;
                        addr_q       <= alu_result_i;
                        funct3_q     <= funct3_i;
                        rd_q         <= rd_i;
                        reg_write_q  <= reg_write_i;
                        mem_to_reg_q <= mem_to_reg_i;
                        req_q        <= 1'b1;
                        we_q         <= mem_write_i;
                        be_q         <= be_d;
                        wdata_q      <= wdata_d;
                    end else if (valid_i) begin
                        valid_q          <= 1'b1;
                        misaligned_q     <= mem_op;
                        read_data_q      <= '0;
                        alu_result_q     <= alu_result_i;
                        rd_out_q         <= rd_i;
                        reg_write_out_q  <= reg_write_i & ~mem_op;
                        mem_to_reg_out_q <= mem_to_reg_i;
                    end
                end
                StAccess: begin
                    if (done) begin
                        state_q          <= StIdle;
                        req_q            <= 1'b0;
                        valid_q          <= 1'b1;
                        bus_error_q      <= timeout;
                        read_data_q      <= (timeout || we_q) ? 32'h0 : load_d;
                        alu_result_q     <= addr_q;
                        rd_out_q         <= rd_q;
                        reg_write_out_q  <= reg_write_q & ~timeout;
                        mem_to_reg_out_q <= mem_to_reg_q;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign valid_o         = valid_q;
    assign misaligned_o    = misaligned_q;
    assign bus_error_o     = bus_error_q;
    assign read_data_o     = read_data_q;
    assign alu_result_o    = alu_result_q;
    assign rd_o            = rd_out_q;
    assign reg_write_o     = reg_write_out_q;
    assign mem_to_reg_o    = mem_to_reg_out_q;
    assign dmem.dmem_req   = req_q;
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = {addr_q[31:2], 2'b00};
    assign dmem.dmem_be    = be_q;
    assign dmem.dmem_wdata = wdata_q;
endmodule

// File: tb/tb_memory_access.sv
// Directed bench for memory_access: stores, loads, extension, alignment faults, timeout, reset.
module tb_memory_access;
    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i, mem_read_i, mem_write_i, reg_write_i, mem_to_reg_i;
    logic [31:0] alu_result_i, write_data_i;
    logic [2:0]  funct3_i;
    logic [4:0]  rd_i;
    logic        stall_o, valid_o, reg_write_o, mem_to_reg_o, misaligned_o, bus_error_o;
    logic [31:0] read_data_o, alu_result_o;
    logic [4:0]  rd_o;
    int          n_vec = 0;
    int          n_err = 0;

    memory_access_if bus ();

    memory_access #(.TIMEOUT_CYCLES(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .valid_i      (valid_i),
        .alu_result_i (alu_result_i),
        .write_data_i (write_data_i),
        .mem_read_i   (mem_read_i),
        .mem_write_i  (mem_write_i),
        .funct3_i     (funct3_i),
        .rd_i         (rd_i),
        .reg_write_i  (reg_write_i),
        .mem_to_reg_i (mem_to_reg_i),
        .stall_o      (stall_o),
        .valid_o      (valid_o),
        .read_data_o  (read_data_o),
        .alu_result_o (alu_result_o),
        .rd_o         (rd_o),
        .reg_write_o  (reg_write_o),
        .mem_to_reg_o (mem_to_reg_o),
        .misaligned_o (misaligned_o),
        .bus_error_o  (bus_error_o),
        .dmem         (bus.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic v, input logic rd_en, input logic wr_en, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd,
                      input logic rw, input logic m2r);
        valid_i = v; mem_read_i = rd_en; mem_write_i = wr_en; funct3_i = f3;
        alu_result_i = addr; write_data_i = wd; rd_i = rd; reg_write_i = rw; mem_to_reg_i = m2r;
        bus.dmem_ack = 1'b0;
        #1;
    endtask

    task automatic ack(input logic a, input logic [31:0] rdata);
        bus.dmem_ack = a; bus.dmem_rdata = rdata;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        bus.dmem_ack = 1'b0; bus.dmem_rdata = '0;
        op(0, 0, 0, 3'b000, 32'h0, 32'h0, 5'd0, 0, 0);
        tick(); tick();
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_req", 32'(bus.dmem_req), 32'd0);
        chk("rst_stall", 32'(stall_o), 32'd0);
        chk("rst_rdata", read_data_o, 32'h0);
        rst = 1'b0;
        tick();

        // SW 0xDEADBEEF @0x100, ack first cycle
        op(1, 0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 5'd0, 0, 0);
        chk("sw_stall_c0", 32'(stall_o), 32'd1);
        tick();
        chk("sw_req", 32'(bus.dmem_req), 32'd1);
        chk("sw_we", 32'(bus.dmem_we), 32'd1);
        chk("sw_addr", bus.dmem_addr, 32'h100);
        chk("sw_be", 32'(bus.dmem_be), 32'hF);
        chk("sw_wdata", bus.dmem_wdata, 32'hDEADBEEF);
        chk("sw_valid_c1", 32'(valid_o), 32'd0);
        ack(1, 32'h0);
        chk("sw_stall_ack", 32'(stall_o), 32'd0);
        tick();
        chk("sw_valid_c2", 32'(valid_o), 32'd1);
        chk("sw_req_drop", 32'(bus.dmem_req), 32'd0);

        // LB @0x103 then LBU same
        op(1, 1, 0, 3'b000, 32'h103, 32'h0, 5'd5, 1, 1);
        tick();
        chk("lb_be", 32'(bus.dmem_be), 32'h8);
        chk("lb_addr", bus.dmem_addr, 32'h100);
        chk("lb_we", 32'(bus.dmem_we), 32'd0);
        ack(1, 32'h80FF_FFFF);
        tick();
        chk("lb_valid", 32'(valid_o), 32'd1);
        chk("lb_data", read_data_o, 32'hFFFF_FF80);
        chk("lb_rd", 32'(rd_o), 32'd5);
        chk("lb_rw", 32'(reg_write_o), 32'd1);
        chk("lb_alu", alu_result_o, 32'h103);
        op(1, 1, 0, 3'b100, 32'h103, 32'h0, 5'd6, 1, 1);
        tick();
        chk("lbu_valid_pulse", 32'(valid_o), 32'd0);
        ack(1, 32'h80FF_FFFF);
        tick();
        chk("lbu_data", read_data_o, 32'h0000_0080);

        // LH @0x102 with ack three cycles late
        op(1, 1, 0, 3'b001, 32'h102, 32'h0, 5'd8, 1, 1);
        chk("lh_stall0", 32'(stall_o), 32'd1);
        for (int i = 1; i <= 3; i++) begin
            tick();
            ack(0, 32'h8001_0000);
            chk($sformatf("lh_stall%0d", i), 32'(stall_o), 32'd1);
        end
        tick();
        ack(1, 32'h8001_0000);
        chk("lh_stall_ack", 32'(stall_o), 32'd0);
        tick();
        chk("lh_data", read_data_o, 32'hFFFF_8001);
        chk("lh_buserr", 32'(bus_error_o), 32'd0);
        chk("lh_rw", 32'(reg_write_o), 32'd1);

        // Misaligned LW and reserved size
        op(1, 1, 0, 3'b010, 32'h101, 32'h0, 5'd7, 1, 1);
        chk("lw_mis_stall", 32'(stall_o), 32'd0);
        tick();
        chk("lw_mis_flag", 32'(misaligned_o), 32'd1);
        chk("lw_mis_valid", 32'(valid_o), 32'd1);
        chk("lw_mis_rw", 32'(reg_write_o), 32'd0);
        chk("lw_mis_req", 32'(bus.dmem_req), 32'd0);
        chk("lw_mis_rd", 32'(rd_o), 32'd7);
        op(1, 1, 0, 3'b011, 32'h100, 32'h0, 5'd7, 1, 1);
        tick();
        chk("f3_011_flag", 32'(misaligned_o), 32'd1);
        chk("f3_011_req", 32'(bus.dmem_req), 32'd0);
        op(0, 0, 0, 3'b000, 32'h0, 32'h0, 5'd0, 0, 0);
        tick();
        chk("mis_pulse_clr", 32'(misaligned_o), 32'd0);

        // Non-memory op passes straight through
        op(1, 0, 0, 3'b000, 32'h1234_5678, 32'h0, 5'd3, 1, 0);
        chk("alu_stall", 32'(stall_o), 32'd0);
        tick();
        chk("alu_valid", 32'(valid_o), 32'd1);
        chk("alu_result", alu_result_o, 32'h1234_5678);
        chk("alu_rdata", read_data_o, 32'h0);
        chk("alu_rw", 32'(reg_write_o), 32'd1);

        // SB / SH lane steering
        op(1, 0, 1, 3'b000, 32'h102, 32'h0000_00A5, 5'd0, 0, 0);
        tick();
        chk("sb_be", 32'(bus.dmem_be), 32'h4);
        chk("sb_wdata", bus.dmem_wdata, 32'hA5A5_A5A5);
        ack(1, 32'h0);
        tick();
        op(1, 1, 1, 3'b001, 32'h102, 32'h0000_1234, 5'd0, 0, 0);
        tick();
        chk("sh_be", 32'(bus.dmem_be), 32'hC);
        chk("sh_wdata", bus.dmem_wdata, 32'h1234_1234);
        chk("sh_store_wins", 32'(bus.dmem_we), 32'd1);
        ack(1, 32'hFFFF_FFFF);
        tick();
        chk("sh_rdata_zero", read_data_o, 32'h0);

        // Timeout with TIMEOUT_CYCLES=4
        op(1, 1, 0, 3'b010, 32'h200, 32'h0, 5'd9, 1, 1);
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk($sformatf("to_stall%0d", i), 32'(stall_o), 32'd1);
        end
        tick();
        chk("to_release", 32'(stall_o), 32'd0);
        chk("to_req_held", 32'(bus.dmem_req), 32'd1);
        tick();
        chk("to_buserr", 32'(bus_error_o), 32'd1);
        chk("to_valid", 32'(valid_o), 32'd1);
        chk("to_rw", 32'(reg_write_o), 32'd0);
        chk("to_rdata", read_data_o, 32'h0);
        chk("to_req_drop", 32'(bus.dmem_req), 32'd0);
        op(0, 0, 0, 3'b000, 32'h0, 32'h0, 5'd0, 0, 0);
        tick();
        chk("to_pulse_clr", 32'(bus_error_o), 32'd0);

        // Reset in the middle of an access
        op(1, 1, 0, 3'b010, 32'h300, 32'h0, 5'd4, 1, 1);
        tick();
        chk("rm_req", 32'(bus.dmem_req), 32'd1);
        op(0, 0, 0, 3'b000, 32'h0, 32'h0, 5'd0, 0, 0);
        rst = 1'b1;
        #1;
        chk("rm_req_drop", 32'(bus.dmem_req), 32'd0);
        tick();
        chk("rm_no_valid", 32'(valid_o), 32'd0);
        rst = 1'b0;
        tick();
        op(1, 1, 0, 3'b010, 32'h300, 32'h0, 5'd4, 1, 1);
        tick();
        ack(1, 32'hCAFE_F00D);
        tick();
        chk("rm_after_valid", 32'(valid_o), 32'd1);
        chk("rm_after_data", read_data_o, 32'hCAFE_F00D);
        op(0, 0, 0, 3'b000, 32'h0, 32'h0, 5'd0, 0, 0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
